// File: rtl/reg_bus_arbiter_pkg.sv
// reg_bus_arbiter_pkg: register-bus request type, arbiter states and read latency shared with Registers
package reg_bus_arbiter_pkg;
  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 32;
  localparam int REG_RD_LATENCY = 1;
  typedef struct packed {
    logic Wr;
    logic [REG_ADDR_W-1:0] Address;
    logic [REG_DATA_W-1:0] WrData;
  } REG_BUS_REQ;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} ARB_STATE;
endpackage

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sharing of the Registers bus between UART Control (0) and a local master (1)
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int RD_LATENCY = REG_RD_LATENCY
) (
  input  logic              ipClk,
  input  logic              ipnReset,
  input  logic              ipReq0,
  input  logic              ipReq1,
  input  logic              ipWr0,
  input  logic              ipWr1,
  input  logic [ADDR_W-1:0] ipAddr0,
  input  logic [ADDR_W-1:0] ipAddr1,
  input  logic [DATA_W-1:0] ipWrData0,
  input  logic [DATA_W-1:0] ipWrData1,
  output logic              opAck0,
  output logic              opAck1,
  output logic [DATA_W-1:0] opRdData0,
  output logic [DATA_W-1:0] opRdData1,
  output logic [ADDR_W-1:0] opAddress,
  output logic [DATA_W-1:0] opWrData,
  output logic              opWrEnable,
  input  logic [DATA_W-1:0] ipRdData,
  output logic              opBusy
);
  localparam logic [2:0] LAT = 3'(RD_LATENCY);
  ARB_STATE state, nextState;
  logic winner, nextWinner, lastServed, latWr, grant, capture;
  logic [2:0] waitCnt;
  always_comb begin
    nextState = state;
    nextWinner = ipReq1 && (!ipReq0 || !lastServed);
    case (state)
      IDLE:    nextState = (ipReq0 || ipReq1) ? ISSUE : IDLE;
      ISSUE:   nextState = latWr ? ACK : WAIT;
      WAIT:    nextState = (waitCnt >= LAT) ? ACK : WAIT;
      default: nextState = IDLE;
    endcase
  end
  assign grant = (state == IDLE) && (nextState == ISSUE);
  // ISSUE is the first counted read cycle; data is sampled at the end of cycle LAT
  assign capture = (state == ISSUE || state == WAIT) && !latWr && (waitCnt == LAT);
  assign opWrEnable = (state == ISSUE) && latWr;
  assign opAck0 = (state == ACK) && !winner;
  assign opAck1 = (state == ACK) && winner;
  assign opBusy = state != IDLE;
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      state <= IDLE;
      winner <= 1'b0;
      lastServed <= 1'b1;
      latWr <= 1'b0;
      waitCnt <= '0;
      opAddress <= '0;
      opWrData <= '0;
      opRdData0 <= '0;
      opRdData1 <= '0;
    end else begin
      state <= nextState;
      if (grant) begin
        winner <= nextWinner;
        latWr <= nextWinner ? ipWr1 : ipWr0;
        opAddress <= nextWinner ? ipAddr1 : ipAddr0;
        opWrData <= nextWinner ? ipWrData1 : ipWrData0;
      end
      waitCnt <= grant ? 3'd1 : (state == ISSUE || state == WAIT) ? waitCnt + 3'd1 : 3'd0;
      if (nextState == ACK && state != ACK) lastServed <= winner;
      if (capture && !winner) opRdData0 <= ipRdData;
      if (capture && winner) opRdData1 <= ipRdData;
    end
  end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: scoreboard bench driving three arbiters (read latency 1, 2, 4) with shared requests
module tb_reg_bus_arbiter;
  localparam logic [11:0] LATS = {4'd4, 4'd2, 4'd1};
  typedef struct {int r; bit wr; logic [31:0] d;} exp_t;
  logic ipClk, ipnReset;
  logic ipReq0, ipReq1, ipWr0, ipWr1;
  logic [7:0] ipAddr0, ipAddr1;
  logic [31:0] ipWrData0, ipWrData1;
  logic ack0 [3], ack1 [3], wrEn [3], busy [3];
  logic [31:0] rd0 [3], rd1 [3], wd [3], rdIn [3];
  logic [7:0] addr [3];
  exp_t sbq [$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0;
  function automatic logic [31:0] rdModel(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {8'h5A, a, ~a, a ^ 8'h3C};
  endfunction
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int L = int'(LATS[g*4+:4]);
    localparam int P = (L > 1) ? L - 2 : 0;
    logic [7:0] aPipe [4];
    always @(posedge ipClk) begin
      aPipe[0] <= addr[g];
      for (int j = 1; j < 4; j++) aPipe[j] <= aPipe[j-1];
    end
    assign rdIn[g] = rdModel((L == 1) ? addr[g] : aPipe[P]);
    reg_bus_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(L)) dut (
      .ipClk(ipClk), .ipnReset(ipnReset),
      .ipReq0(ipReq0), .ipReq1(ipReq1), .ipWr0(ipWr0), .ipWr1(ipWr1),
      .ipAddr0(ipAddr0), .ipAddr1(ipAddr1), .ipWrData0(ipWrData0), .ipWrData1(ipWrData1),
      .opAck0(ack0[g]), .opAck1(ack1[g]), .opRdData0(rd0[g]), .opRdData1(rd1[g]),
      .opAddress(addr[g]), .opWrData(wd[g]), .opWrEnable(wrEn[g]),
      .ipRdData(rdIn[g]), .opBusy(busy[g])
    );
  end
  initial ipClk = 0;
  always #5 ipClk = ~ipClk;
  always @(posedge ipClk) cyc++;
  // scoreboard on the latency-1 instance: every ack pops the oldest expected transaction
  always @(negedge ipClk) begin
    if (ipnReset && (ack0[0] || ack1[0])) begin
      checks++;
      if (ack0[0] && ack1[0]) begin
        errors++;
        $display("FAIL both_acks got ack0=%0b ack1=%0b want not both", ack0[0], ack1[0]);
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack got ack0=%0b ack1=%0b want none", ack0[0], ack1[0]);
      end else begin
        e = sbq.pop_front();
        if ((ack1[0] ? 1 : 0) !== e.r) begin
          errors++;
          $display("FAIL ack_winner got %0d want %0d", ack1[0] ? 1 : 0, e.r);
        end
        if (!e.wr) begin
          checks++;
          if ((ack1[0] ? rd1[0] : rd0[0]) !== e.d) begin
            errors++;
            $display("FAIL rd_data got %h want %h", ack1[0] ? rd1[0] : rd0[0], e.d);
          end
        end
      end
    end
  end
  task automatic clr();
    ipReq0 = 0; ipReq1 = 0; ipWr0 = 0; ipWr1 = 0;
    ipAddr0 = 0; ipAddr1 = 0; ipWrData0 = 0; ipWrData1 = 0;
  endtask
  task automatic do_reset(input int n);
    @(posedge ipClk); #1;
    ipnReset = 0;
    clr();
    repeat (n) @(posedge ipClk);
    #1 ipnReset = 1;
  endtask
  task automatic test_reset();
    ipnReset = 0;
    clr();
    repeat (3) @(negedge ipClk);
    checks++;
    if ({ack0[0], ack1[0], wrEn[0], busy[0]} !== 4'b0 || addr[0] !== 0 || wd[0] !== 0 || rd0[0] !== 0 || rd1[0] !== 0) begin
      errors++;
      $display("FAIL reset_values got ack=%b%b we=%b busy=%b addr=%h wd=%h rd0=%h rd1=%h want all zero",
               ack0[0], ack1[0], wrEn[0], busy[0], addr[0], wd[0], rd0[0], rd1[0]);
    end
    @(posedge ipClk); #1 ipnReset = 1;
    repeat (2) @(negedge ipClk);
    checks++;
    if (busy[0] !== 0 || wrEn[0] !== 0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b we=%b want 0 0", busy[0], wrEn[0]);
    end
  endtask
  task automatic test_write();
    int t, lat = -1, nWe = 0, weCyc = -1;
    logic [7:0] wa = 0;
    logic [31:0] wdv = 0;
    @(posedge ipClk); #1;
    t = cyc;
    ipReq0 = 1; ipWr0 = 1; ipAddr0 = 8'h04; ipWrData0 = 32'hA5;
    sbq.push_back('{0, 1'b1, 32'h0});
    for (int k = 0; k < 10 && lat < 0; k++) begin
      @(negedge ipClk);
      if (wrEn[0]) begin nWe++; wa = addr[0]; wdv = wd[0]; weCyc = cyc - t; end
      if (ack0[0]) lat = cyc - t;
    end
    @(posedge ipClk); #1 ipReq0 = 0;
    repeat (3) begin
      @(negedge ipClk);
      if (wrEn[0]) nWe++;
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL write_ack_latency got %0d want 2", lat); end
    checks++;
    if (weCyc !== 1) begin errors++; $display("FAIL write_strobe_cycle got %0d want 1", weCyc); end
    checks++;
    if (nWe !== 1) begin errors++; $display("FAIL write_strobe_count got %0d want 1", nWe); end
    checks++;
    if (wa !== 8'h04 || wdv !== 32'hA5) begin
      errors++;
      $display("FAIL write_bus got addr=%h data=%h want 04 000000a5", wa, wdv);
    end
  endtask
  task automatic test_read();
    int t, lat = -1, nWe = 0;
    @(posedge ipClk); #1;
    t = cyc;
    ipReq1 = 1; ipWr1 = 0; ipAddr1 = 8'h10;
    sbq.push_back('{1, 1'b0, 32'hDEADBEEF});
    for (int k = 0; k < 10 && lat < 0; k++) begin
      @(negedge ipClk);
      if (wrEn[0]) nWe++;
      if (ack1[0]) lat = cyc - t;
    end
    @(posedge ipClk); #1 ipReq1 = 0;
    @(negedge ipClk);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_ack_latency got %0d want 3", lat); end
    checks++;
    if (nWe !== 0) begin errors++; $display("FAIL read_no_strobe got %0d want 0", nWe); end
    checks++;
    if (rd1[0] !== 32'hDEADBEEF || rd0[0] !== 32'h0) begin
      errors++;
      $display("FAIL read_hold got rd1=%h rd0=%h want deadbeef 00000000", rd1[0], rd0[0]);
    end
  endtask
  task automatic test_alternate();
    int seq [8];
    int got = 0;
    do_reset(2);
    @(posedge ipClk); #1;
    ipWr0 = 1; ipWr1 = 1; ipAddr0 = 8'h08; ipAddr1 = 8'h0C;
    ipWrData0 = 32'h1111_0000; ipWrData1 = 32'h2222_0000;
    ipReq0 = 1; ipReq1 = 1;
    for (int i = 0; i < 8; i++) sbq.push_back('{i % 2, 1'b1, 32'h0});
    for (int k = 0; k < 60 && got < 8; k++) begin
      @(negedge ipClk);
      if (ack0[0] || ack1[0]) begin seq[got] = ack1[0] ? 1 : 0; got++; end
    end
    @(posedge ipClk); #1 clr();
    @(negedge ipClk);
    checks++;
    if (got !== 8) begin errors++; $display("FAIL alternate_count got %0d want 8", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (seq[i] !== i % 2) begin errors++; $display("FAIL alternate_order[%0d] got %0d want %0d", i, seq[i], i % 2); end
    end
    checks++;
    if (rd0[0] !== 0 || rd1[0] !== 0) begin
      errors++;
      $display("FAIL write_keeps_rddata got rd0=%h rd1=%h want 0 0", rd0[0], rd1[0]);
    end
  endtask
  task automatic test_addr_hold();
    bit seen = 0;
    @(posedge ipClk); #1;
    ipReq0 = 1; ipWr0 = 0; ipAddr0 = 8'h20;
    sbq.push_back('{0, 1'b0, rdModel(8'h20)});
    @(posedge ipClk); #1 ipAddr0 = 8'hFF;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge ipClk);
      checks++;
      if (addr[0] !== 8'h20) begin errors++; $display("FAIL addr_hold got %h want 20", addr[0]); end
      seen = ack0[0];
    end
    @(posedge ipClk); #1 clr();
    checks++;
    if (!seen) begin errors++; $display("FAIL addr_hold_timeout got no ack want ack0"); end
  endtask
  task automatic test_sweep();
    int t;
    int lat [3] = '{-1, -1, -1};
    int want [3] = '{3, 3, 5};
    logic [31:0] dat [3];
    do_reset(2);
    @(posedge ipClk); #1;
    t = cyc;
    ipReq1 = 1; ipWr1 = 0; ipAddr1 = 8'h10;
    sbq.push_back('{1, 1'b0, 32'hDEADBEEF});
    // dropped once granted: the transaction must still run to its ack
    @(posedge ipClk); #1 ipReq1 = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge ipClk);
      for (int i = 0; i < 3; i++)
        if (ack1[i] && lat[i] < 0) begin lat[i] = cyc - t; dat[i] = rd1[i]; end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lat[i] !== want[i] || dat[i] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL sweep_lat%0d got lat=%0d data=%h want lat=%0d data=deadbeef", int'(LATS[i*4+:4]), lat[i], dat[i], want[i]);
      end
    end
  endtask
  task automatic test_reset_mid();
    int bad = 0;
    @(posedge ipClk); #1;
    ipReq0 = 1; ipWr0 = 0; ipAddr0 = 8'h30;
    repeat (2) @(posedge ipClk);
    #1 ipnReset = 0; clr();
    #1;
    checks++;
    if (busy[0] !== 0 || busy[2] !== 0) begin errors++; $display("FAIL reset_abort got busy=%b/%b want 0", busy[0], busy[2]); end
    repeat (5) begin
      @(negedge ipClk);
      for (int i = 0; i < 3; i++) if (ack0[i] || ack1[i] || busy[i]) bad++;
    end
    @(posedge ipClk); #1 ipnReset = 1;
    repeat (4) begin
      @(negedge ipClk);
      for (int i = 0; i < 3; i++) if (ack0[i] || ack1[i] || busy[i]) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL reset_mid_read got %0d ack/busy cycles want 0", bad); end
    @(posedge ipClk); #1;
    ipReq0 = 1; ipWr0 = 1; ipAddr0 = 8'h40; ipWrData0 = 32'h5;
    @(posedge ipClk); #1;
    checks++;
    if (wrEn[0] !== 1) begin errors++; $display("FAIL strobe_before_reset got %b want 1", wrEn[0]); end
    #2 ipnReset = 0; clr();
    #1;
    checks++;
    if (wrEn[0] !== 0) begin errors++; $display("FAIL strobe_cut got %b want 0", wrEn[0]); end
    @(posedge ipClk); #1 ipnReset = 1;
    repeat (3) @(negedge ipClk);
    checks++;
    if (ack0[0] !== 0 || busy[0] !== 0) begin errors++; $display("FAIL idle_after_cut got ack=%b busy=%b want 0 0", ack0[0], busy[0]); end
  endtask
  task automatic test_drain();
    checks++;
    if (sbq.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size()); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_alternate();
    test_addr_hold();
    test_sweep();
    test_reset_mid();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
